// File: rtl/mult_share_ctrl.sv
// Two-requester arbiter sharing one shift-add WIDTHxWIDTH multiplier.
// Grants one requester, runs WIDTH add/shift steps, then pulses that requester's done.
module mult_share_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRIO_FIXED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               owner
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 last_reg;
  logic                 owner_reg;
  logic                 gnt0_reg, gnt1_reg;
  logic                 done0_reg, done1_reg;
  logic                 busy_reg;
  logic [2*WIDTH-1:0]   result_reg;

  logic                 win_next;
  logic [2*WIDTH-1:0]   acc_next;

  // On a tie the requester not served last wins, unless priority is fixed to requester 0.
  always_comb begin
    win_next = req1;
    if (req0 && req1) begin
      win_next = (PRIO_FIXED != 0) ? 1'b0 : ~last_reg;
    end
  end

  always_comb begin
    acc_next = acc_reg;
    if (mplier_reg[0]) begin
      acc_next = acc_reg + ({{WIDTH{1'b0}}, mcand_reg} << cnt_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      gnt0_reg   <= 1'b0;
      gnt1_reg   <= 1'b0;
      done0_reg  <= 1'b0;
      done1_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          gnt0_reg  <= 1'b0;
          gnt1_reg  <= 1'b0;
          done0_reg <= 1'b0;
          done1_reg <= 1'b0;
          if (req0 || req1) begin
            mcand_reg  <= win_next ? a1 : a0;
            mplier_reg <= win_next ? b1 : b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            owner_reg  <= win_next;
            gnt0_reg   <= ~win_next;
            gnt1_reg   <= win_next;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          gnt0_reg   <= 1'b0;
          gnt1_reg   <= 1'b0;
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_STEP) begin
            result_reg <= acc_next;
            done0_reg  <= ~owner_reg;
            done1_reg  <= owner_reg;
            last_reg   <= owner_reg;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done0_reg <= 1'b0;
          done1_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt0   = gnt0_reg;
  assign gnt1   = gnt1_reg;
  assign done0  = done0_reg;
  assign done1  = done1_reg;
  assign result = result_reg;
  assign busy   = busy_reg;
  assign owner  = owner_reg;

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencing controller and arbiter that shares one shift-add WIDTH×WIDTH multiplier between two requesters: the manual key-entry multiply path (requester 0) and the auto-increment multiply path (requester 1). It captures the granted requester's operands and runs WIDTH add/shift iterations. It then returns the 2·WIDTH-bit product with a per-requester done pulse. It sits between the key/state logic and the seven-segment number mux and replaces per-path multiplier instances.

## Interface
- WIDTH, 8, operand width; product is 2·WIDTH bits
- PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 request (level)
- a0, b0  in  WIDTH each  requester 0 operands
- req1  in  1  requester 1 request (level)
- a1, b1  in  WIDTH each  requester 1 operands
- gnt0, gnt1  out  1 each  one-cycle grant pulse
- done0, done1  out  1 each  one-cycle completion pulse
- result  out  2·WIDTH  last product, held until next completion
- busy  out  1  high in CALC and DONE
- owner  out  1  requester currently or last served

## Operation
- Reset, applied at any time including mid-operation: state IDLE; gnt0/1, done0/1 and busy are 0; result = 0; owner = 0. The round-robin pointer last = 1, so requester 0 wins the first tie. No done pulse is issued for an aborted operation.
- The FSM has three states: IDLE, CALC and DONE.
- IDLE, edge with req0 or req1 high:
  - Choose the winner w. If only one requester is asserting, it wins. If both are asserting, the winner is the one not equal to last; with PRIO_FIXED=1 the winner is always 0.
  - Latch a_w into mcand and b_w into mplier. Clear acc and cnt.
  - Set owner = w, pulse gnt_w = 1, and go to CALC.
- IDLE with no request: stay in IDLE; all pulses stay 0.
- CALC, each edge:
  - If mplier[0] = 1, acc ← acc + (mcand << cnt); the addition is 2·WIDTH bits wide and cannot overflow.
  - mplier ← mplier >> 1 and cnt ← cnt + 1.
  - On the edge that executes step cnt = WIDTH−1: result ← final acc, pulse done_owner = 1, set last = owner, and go to DONE.
- DONE: on the next edge, clear done and go to IDLE. No arbitration happens in DONE.
- Operands are sampled only on the grant edge. Later changes to a/b, or deassertion of req, have no effect on the running operation. A dropped request still completes and its done still pulses.
- A req held high after done is treated as a new request in the following IDLE cycle (back-to-back).
- A requester that is not granted keeps waiting; its req is level-sensitive and is never lost.
- Zero operands still take the full WIDTH iterations.

## Timing
- Let the grant edge be E0.
- gnt_w is high for the cycle after E0 only.
- Iterations execute on edges E1..EWIDTH. done_w and the new result appear after EWIDTH: high for one cycle, WIDTH cycles after gnt rose.
- The edge EWIDTH+1 returns to IDLE. The earliest next grant is EWIDTH+2, so sustained throughput is one product per WIDTH+2 cycles (10 cycles at WIDTH=8).
- busy = 1 from after E0 through the DONE cycle.
- gnt0/gnt1 and done0/done1 are never high together, and never high in the same cycle as each other's counterpart.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset values: assert rst for 3 cycles with both reqs high → all outputs 0, no gnt. Release rst → gnt0 the next cycle.
- Single request: req0 = 1, a0 = 3, b0 = 5 for one cycle → gnt0 one cycle later, done0 8 cycles after gnt0, result = 15 held; done1 and gnt1 stay 0 throughout.
- Extremes: a1 = 255, b1 = 255 → result = 0xFE01. a0 = 0, b0 = 200 → result = 0, still 8 iterations.
- Round-robin contention: req0 and req1 held high, a0 = 12, b0 = 10, a1 = 7, b1 = 9 → grants alternate 0, 1, 0, 1 with results 120, 63, 120, 63. Grants are exactly 10 cycles apart.
- Fixed priority: PRIO_FIXED = 1 with both reqs held high → only gnt0/done0 ever pulse. Drop req0 → gnt1 at the next IDLE.
- Mid-operation disturbance:
  - Change a0 after gnt0 → result uses the latched value.
  - Assert rst during CALC cycle 4 → no done, result = 0, state IDLE. The next req1 (a1 = 6, b1 = 7) is granted and yields 42.
